// File: rtl/mxint_block_encoder.sv
// Streaming MX-int block encoder: gathers k signed fixed-point elements, derives one
// shared right-shift from the OR of their magnitude codes, and emits mantissas plus scale.
module mxint_block_encoder #(
  parameter int IN_WIDTH    = 32,
  parameter int k           = 2,
  parameter int MAN_WIDTH   = 8,
  parameter int scale_width = 8
) (
  input  logic                          i_clk,
  input  logic                          i_rst_n,
  input  logic signed [IN_WIDTH-1:0]    i_data,
  input  logic        [scale_width-1:0] i_scale,
  input  logic                          i_valid,
  output logic                          o_ready,
  output logic [k-1:0][MAN_WIDTH:0]     o_man,
  output logic        [scale_width-1:0] o_scale,
  output logic                          o_sat,
  output logic                          o_valid,
  input  logic                          i_ready
);

  localparam int CW   = (k > 1) ? $clog2(k) : 1;
  localparam int SW   = $clog2(IN_WIDTH) + 1;
  localparam int SUMW = ((scale_width > SW) ? scale_width : SW) + 1;

  typedef enum logic [1:0] {
    ST_COLLECT,
    ST_CALC,
    ST_EMIT
  } state_t;

  state_t                       r_state;
  state_t                       w_state_next;
  logic        [CW-1:0]         r_cnt;
  logic        [IN_WIDTH-1:0]   r_acc;
  logic        [scale_width-1:0] r_scale_in;
  logic signed [IN_WIDTH-1:0]   r_elem [k];

  logic                         w_accept;
  logic                         w_last;
  logic                         w_emit_done;
  logic        [IN_WIDTH-1:0]   w_mag;
  logic        [SW-1:0]         w_shift;
  logic        [SUMW-1:0]       w_sum;
  logic                         w_sat;
  logic [k-1:0][MAN_WIDTH:0]    w_man;

  assign w_accept = i_valid & o_ready;
  assign w_last   = (r_cnt == CW'(k - 1));
  // One's-complement magnitude: an element fits W signed bits iff this code is below 2^(W-1).
  assign w_mag    = i_data ^ {IN_WIDTH{i_data[IN_WIDTH-1]}};

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_state <= ST_COLLECT;
    end else begin
      r_state <= w_state_next;
    end
  end

  always_comb begin
    w_state_next = r_state;
    o_ready      = 1'b0;
    o_valid      = 1'b0;
    w_emit_done  = 1'b0;
    case (r_state)
      ST_COLLECT: begin
        o_ready = 1'b1;
        if (i_valid && w_last) begin
          w_state_next = ST_CALC;
        end
      end
      ST_CALC: begin
        w_state_next = ST_EMIT;
      end
      ST_EMIT: begin
        o_valid = 1'b1;
        if (i_ready) begin
          w_emit_done  = 1'b1;
          w_state_next = ST_COLLECT;
        end
      end
      default: begin
        w_state_next = ST_COLLECT;
      end
    endcase
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_cnt      <= '0;
      r_acc      <= '0;
      r_scale_in <= '0;
    end else begin
      if (w_accept) begin
        r_cnt <= w_last ? '0 : r_cnt + 1'b1;
        r_acc <= r_acc | w_mag;
        if (r_cnt == '0) begin
          r_scale_in <= i_scale;
        end
      end
      if (w_emit_done) begin
        r_acc <= '0;
      end
    end
  end

  // Element storage needs no reset: every slot is rewritten before a block is emitted.
  always_ff @(posedge i_clk) begin
    if (w_accept) begin
      r_elem[r_cnt] <= i_data;
    end
  end

  // Ascending scan so the highest set bit of the accumulator decides the shift.
  always_comb begin
    w_shift = '0;
    for (int b = 0; b < IN_WIDTH; b++) begin
      if (r_acc[b] && (b + 1 > MAN_WIDTH)) begin
        w_shift = SW'(b + 1 - MAN_WIDTH);
      end
    end
  end

  genvar gi;
  generate
    for (gi = 0; gi < k; gi++) begin : g_man
      assign w_man[gi] = (MAN_WIDTH + 1)'(r_elem[gi] >>> w_shift);
    end
  endgenerate

  assign w_sum = SUMW'(r_scale_in) + SUMW'(w_shift);
  assign w_sat = (w_sum > SUMW'({scale_width{1'b1}}));

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      o_man   <= '0;
      o_scale <= '0;
      o_sat   <= 1'b0;
    end else if (r_state == ST_CALC) begin
      o_man   <= w_man;
      o_scale <= w_sat ? '1 : w_sum[scale_width-1:0];
      o_sat   <= w_sat;
    end
  end

endmodule

// File: tb/tb_mxint_block_encoder.sv
// Randomized and directed bench for mxint_block_encoder; expected values come from a
// search for the smallest shift that makes every element fit the signed mantissa.
module tb_mxint_block_encoder;

  localparam int IW  = 16;
  localparam int K   = 2;
  localparam int MW  = 8;
  localparam int SCW = 8;

  logic                     clk = 1'b0;
  logic                     i_rst_n = 1'b0;
  logic signed [IW-1:0]     i_data = '0;
  logic        [SCW-1:0]    i_scale = '0;
  logic                     i_valid = 1'b0;
  logic                     o_ready;
  logic [K-1:0][MW:0]       o_man;
  logic        [SCW-1:0]    o_scale;
  logic                     o_sat;
  logic                     o_valid;
  logic                     i_ready = 1'b1;

  int n_total = 0;
  int n_pass  = 0;

  int cur_x [K];
  int cur_sc;
  int exp_m [K];
  int exp_sc;
  int exp_sat;

  mxint_block_encoder #(
    .IN_WIDTH   (IW),
    .k          (K),
    .MAN_WIDTH  (MW),
    .scale_width(SCW)
  ) dut (
    .i_clk  (clk),
    .i_rst_n(i_rst_n),
    .i_data (i_data),
    .i_scale(i_scale),
    .i_valid(i_valid),
    .o_ready(o_ready),
    .o_man  (o_man),
    .o_scale(o_scale),
    .o_sat  (o_sat),
    .o_valid(o_valid),
    .i_ready(i_ready)
  );

  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

  task automatic check_val(input string tag, input longint got, input longint exp);
    n_total++;
    if (got == exp) n_pass++;
    else $display("FAIL %s: got %0d expected %0d", tag, got, exp);
  endtask

  function automatic void compute_model();
    int  s;
    bit  fits;
    int  sum;
    s = 0;
    fits = 1'b0;
    while (!fits) begin
      fits = 1'b1;
      for (int e = 0; e < K; e++) begin
        int v;
        v = cur_x[e] >>> s;
        if (v > (1 << MW) - 1 || v < -(1 << MW)) fits = 1'b0;
      end
      if (!fits) s++;
    end
    for (int e = 0; e < K; e++) exp_m[e] = cur_x[e] >>> s;
    sum = cur_sc + s;
    if (sum > (1 << SCW) - 1) begin
      exp_sc  = (1 << SCW) - 1;
      exp_sat = 1;
    end else begin
      exp_sc  = sum;
      exp_sat = 0;
    end
  endfunction

  task automatic check_outputs(input string tag);
    compute_model();
    for (int e = 0; e < K; e++) begin
      int got;
      got = int'($signed(o_man[e]));
      check_val($sformatf("%s_man%0d", tag, e), got, exp_m[e]);
    end
    check_val({tag, "_scale"}, o_scale, exp_sc);
    check_val({tag, "_sat"}, o_sat, exp_sat);
  endtask

  task automatic check_reset_outputs(input string tag);
    check_val({tag, "_valid"}, o_valid, 0);
    check_val({tag, "_ready"}, o_ready, 1);
    check_val({tag, "_scale"}, o_scale, 0);
    check_val({tag, "_sat"}, o_sat, 0);
    check_val({tag, "_man"}, o_man, 0);
  endtask

  // Called at a falling edge; returns at the falling edge after the element was taken.
  task automatic send_elem(input int x, input int sc);
    int n;
    n = 0;
    while (!o_ready && n < 50) begin
      @(negedge clk);
      n++;
    end
    if (!o_ready) check_val("ready_wait", o_ready, 1);
    i_valid = 1'b1;
    i_data  = x[IW-1:0];
    i_scale = sc[SCW-1:0];
    @(negedge clk);
    i_valid = 1'b0;
    i_data  = IW'($urandom);
    i_scale = SCW'($urandom);
  endtask

  task automatic send_elems(input int gap, input bit jitter);
    for (int e = 0; e < K; e++) begin
      int sc;
      repeat (gap) @(negedge clk);
      sc = (e == 0 || !jitter) ? cur_sc : int'($urandom_range(0, 255));
      send_elem(cur_x[e], sc);
    end
  endtask

  task automatic wait_valid();
    int n;
    n = 0;
    while (!o_valid && n < 20) begin
      @(negedge clk);
      n++;
    end
    check_val("valid_wait", o_valid, 1);
    check_val("latency", n, 1);
  endtask

  task automatic run_block(input string tag, input int gap, input int stall, input bit jitter);
    i_ready = (stall == 0);
    send_elems(gap, jitter);
    wait_valid();
    check_outputs(tag);
    for (int c = 0; c < stall; c++) begin
      @(negedge clk);
      check_val("bp_valid", o_valid, 1);
      check_val("bp_ready", o_ready, 0);
      check_outputs({tag, "_bp"});
    end
    i_ready = 1'b1;
    @(negedge clk);
    check_val("drop_valid", o_valid, 0);
    check_val("after_ready", o_ready, 1);
  endtask

  initial begin
    @(negedge clk);
    check_reset_outputs("rst_init");
    @(negedge clk);
    i_rst_n = 1'b1;
    @(negedge clk);
    check_reset_outputs("post_rst");

    cur_x[0] = 100;   cur_x[1] = -50;  cur_sc = 10;  run_block("basic", 0, 0, 0);
    cur_x[0] = 1000;  cur_x[1] = 3;    cur_sc = 10;  run_block("shift2", 0, 0, 0);
    cur_x[0] = -256;  cur_x[1] = 255;  cur_sc = 10;  run_block("edge_fit", 0, 0, 0);
    cur_x[0] = -257;  cur_x[1] = 0;    cur_sc = 10;  run_block("edge_over", 0, 0, 0);
    cur_x[0] = 1000;  cur_x[1] = 0;    cur_sc = 254; run_block("sat", 0, 0, 0);
    cur_x[0] = 1234;  cur_x[1] = -77;  cur_sc = 20;  run_block("stall", 0, 5, 0);
    cur_x[0] = 1000;  cur_x[1] = 3;    cur_sc = 10;  run_block("gaps", 3, 0, 1);

    // Reset while part of a block is collected.
    send_elem(500, 40);
    i_rst_n = 1'b0;
    #1;
    check_reset_outputs("rst_mid_collect");
    @(negedge clk);
    i_rst_n = 1'b1;
    cur_x[0] = 7; cur_x[1] = 8; cur_sc = 3;
    run_block("after_rst", 0, 0, 0);

    // Reset while a block is waiting downstream.
    cur_x[0] = -3000; cur_x[1] = 42; cur_sc = 100;
    i_ready = 1'b0;
    send_elems(0, 0);
    wait_valid();
    #3;
    i_rst_n = 1'b0;
    #1;
    check_reset_outputs("rst_mid_emit");
    @(negedge clk);
    i_rst_n = 1'b1;
    i_ready = 1'b1;
    cur_x[0] = 7; cur_x[1] = 8; cur_sc = 3;
    run_block("after_rst2", 0, 0, 0);

    for (int b = 0; b < 40; b++) begin
      for (int e = 0; e < K; e++) begin
        logic signed [IW-1:0] t;
        int x;
        t = IW'($urandom);
        x = t;
        cur_x[e] = x >>> $urandom_range(0, IW - 1);
      end
      cur_sc = ($urandom_range(0, 3) == 0) ? int'($urandom_range(245, 255))
                                           : int'($urandom_range(0, 255));
      run_block("rand", int'($urandom_range(0, 2)), int'($urandom_range(0, 3)),
                1'($urandom_range(0, 1)));
    end

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
